// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor.
// Two-bit counter encodings and saturating step functions.
package bp_pkg;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_RESET = CTR_WNT;
   localparam logic [1:0] CTR_ALLOC = CTR_WT;

   // Read-port response of the BTB.
   typedef struct packed {
      logic        hit;
      logic [31:0] target;
      logic [1:0]  ctr;
   } bp_rd_t;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == CTR_ST) ? c : c + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == CTR_SNT) ? c : c - 2'd1;
   endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB storage: async lookup for fetch, async probe for the
// resolving branch, and one synchronous write port.
module bp_table
   import bp_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX     = $clog2(ENTRIES),
   parameter int TAG_W   = 30 - IDX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX-1:0]   f_idx,
   input  logic [TAG_W-1:0] f_tag,
   output bp_rd_t           f_rd,
   input  logic [IDX-1:0]   e_idx,
   input  logic [TAG_W-1:0] e_tag,
   output bp_rd_t           e_rd,
   input  logic             we,
   input  logic [IDX-1:0]   wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_target,
   input  logic [1:0]       wr_ctr
);

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag    [ENTRIES];
   logic [31:0]        target [ENTRIES];
   logic [1:0]         ctr    [ENTRIES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag[i]    <= '0;
            target[i] <= '0;
            ctr[i]    <= CTR_RESET;
         end
      end else if (we) begin
         valid[wr_idx]  <= 1'b1;
         tag[wr_idx]    <= wr_tag;
         target[wr_idx] <= wr_target;
         ctr[wr_idx]    <= wr_ctr;
      end
   end

   // No write bypass: a same-cycle lookup sees the pre-update entry.
   always_comb begin
      f_rd.hit    = valid[f_idx] && (tag[f_idx] == f_tag);
      f_rd.target = target[f_idx];
      f_rd.ctr    = ctr[f_idx];
      e_rd.hit    = valid[e_idx] && (tag[e_idx] == e_tag);
      e_rd.target = target[e_idx];
      e_rd.ctr    = ctr[e_idx];
   end

endmodule

// File: rtl/branch_predictor.sv
// BTB-based branch predictor: fetch-stage lookup, prediction pipeline to E,
// training on resolved branches and branch/miss performance counters.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_f,
   output logic        br_pred_f,
   output logic [31:0] br_pred_pc,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        flush_e,
   output logic        br_pred_e,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   output logic        mispredict,
   output logic [31:0] cnt_branch,
   output logic [31:0] cnt_miss
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX;

   bp_rd_t           f_rd, e_rd;
   logic             f_hit;
   logic [1:0]       f_ctr;
   logic             we;
   logic [31:0]      wr_target;
   logic [1:0]       wr_ctr;
   logic             pred_d;
   logic             unused_pc_lsb;

   assign unused_pc_lsb = ^{pc_f[1:0], upd_pc[1:0]};

   bp_table #(.ENTRIES(ENTRIES), .IDX(IDX), .TAG_W(TAG_W)) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .f_idx     (pc_f[IDX+1:2]),
      .f_tag     (pc_f[31:IDX+2]),
      .f_rd      (f_rd),
      .e_idx     (upd_pc[IDX+1:2]),
      .e_tag     (upd_pc[31:IDX+2]),
      .e_rd      (e_rd),
      .we        (we),
      .wr_idx    (upd_pc[IDX+1:2]),
      .wr_tag    (upd_pc[31:IDX+2]),
      .wr_target (wr_target),
      .wr_ctr    (wr_ctr)
   );

   assign f_hit      = f_rd.hit;
   assign f_ctr      = f_rd.ctr;
   assign br_pred_f  = f_rd.hit & f_rd.ctr[1];
   assign br_pred_pc = br_pred_f ? f_rd.target : '0;
   assign mispredict = upd_en & (upd_taken != br_pred_e);

   // Hits train the counter; only taken misses allocate.
   always_comb begin
      we        = 1'b0;
      wr_target = e_rd.target;
      wr_ctr    = e_rd.ctr;
      if (upd_en) begin
         if (e_rd.hit) begin
            we        = 1'b1;
            wr_ctr    = upd_taken ? sat_inc(e_rd.ctr) : sat_dec(e_rd.ctr);
            wr_target = upd_taken ? upd_target : e_rd.target;
         end else if (upd_taken) begin
            we        = 1'b1;
            wr_ctr    = CTR_ALLOC;
            wr_target = upd_target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_d     <= 1'b0;
         br_pred_e  <= 1'b0;
         cnt_branch <= '0;
         cnt_miss   <= '0;
      end else begin
         pred_d     <= flush_d ? 1'b0 : (stall_d ? pred_d : br_pred_f);
         br_pred_e  <= flush_e ? 1'b0 : pred_d;
         cnt_branch <= cnt_branch + {31'b0, upd_en};
         cnt_miss   <= cnt_miss + {31'b0, mispredict};
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16).
module tb_branch_predictor;

   logic        clk, rst_n;
   logic [31:0] pc_f, br_pred_pc, upd_pc, upd_target, cnt_branch, cnt_miss;
   logic        br_pred_f, stall_d, flush_d, flush_e, br_pred_e;
   logic        upd_en, upd_taken, mispredict;

   int n_asrt = 0;
   int n_fail = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .br_pred_f(br_pred_f),
      .br_pred_pc(br_pred_pc), .stall_d(stall_d), .flush_d(flush_d),
      .flush_e(flush_e), .br_pred_e(br_pred_e), .upd_en(upd_en),
      .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .mispredict(mispredict), .cnt_branch(cnt_branch), .cnt_miss(cnt_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [31:0] pc;
      logic        tk;
      logic [31:0] tgt;
      logic [31:0] look;
      logic        exp_pf;
      logic [31:0] exp_ppc;
      logic        exp_hit;
      logic [1:0]  exp_ctr;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_asrt++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;
      logic [9:0] pat;

      //           en    pc          tk    tgt          look        pf    ppc          hit   ctr
      vecs[0]  = '{1'b1, 32'h3010, 1'b1, 32'h3040, 32'h3010, 1'b1, 32'h3040, 1'b1, 2'd2};
      vecs[1]  = '{1'b1, 32'h3010, 1'b1, 32'h3040, 32'h3010, 1'b1, 32'h3040, 1'b1, 2'd3};
      vecs[2]  = '{1'b1, 32'h3010, 1'b1, 32'h3040, 32'h3010, 1'b1, 32'h3040, 1'b1, 2'd3};
      vecs[3]  = '{1'b1, 32'h3010, 1'b1, 32'h3040, 32'h3010, 1'b1, 32'h3040, 1'b1, 2'd3};
      vecs[4]  = '{1'b1, 32'h3010, 1'b0, 32'h0,    32'h3010, 1'b1, 32'h3040, 1'b1, 2'd2};
      vecs[5]  = '{1'b1, 32'h3010, 1'b0, 32'h0,    32'h3010, 1'b0, 32'h0,    1'b1, 2'd1};
      vecs[6]  = '{1'b1, 32'h3050, 1'b1, 32'h3100, 32'h3010, 1'b0, 32'h0,    1'b0, 2'd2};
      vecs[7]  = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h3050, 1'b1, 32'h3100, 1'b1, 2'd2};
      vecs[8]  = '{1'b1, 32'h3050, 1'b0, 32'hDEAD, 32'h3050, 1'b0, 32'h0,    1'b1, 2'd1};
      vecs[9]  = '{1'b1, 32'h4000, 1'b0, 32'h4444, 32'h4000, 1'b0, 32'h0,    1'b0, 2'd1};
      vecs[10] = '{1'b1, 32'h3050, 1'b1, 32'h3200, 32'h3050, 1'b1, 32'h3200, 1'b1, 2'd2};
      vecs[11] = '{1'b0, 32'h0,    1'b0, 32'h0,    32'h3053, 1'b1, 32'h3200, 1'b1, 2'd2};

      // Reset with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pc_f = $urandom; upd_pc = $urandom; upd_target = $urandom;
         upd_en = 1'($urandom); upd_taken = 1'($urandom);
         stall_d = 1'($urandom); flush_d = 1'($urandom); flush_e = 1'($urandom);
         tick();
      end
      chk("rst_pred_f", br_pred_f, 0);
      chk("rst_pred_e", br_pred_e, 0);
      chk("rst_cnt_branch", cnt_branch, 0);
      chk("rst_cnt_miss", cnt_miss, 0);
      upd_en = 0; upd_taken = 0; stall_d = 0; flush_d = 1; flush_e = 1;
      upd_pc = 0; upd_target = 0; pc_f = 0;
      #2 rst_n = 1'b1;
      tick();
      foreach (vecs[i]) begin
         pc_f = vecs[i].look ^ 32'h0000_0100;
         #1;
         chk("rst_lookup_hit", dut.f_hit, 0);
         chk("rst_lookup_pred", br_pred_f, 0);
      end
      upd_en = 1; upd_taken = 1; #1;
      chk("rst_mispredict", mispredict, 1);
      upd_en = 0; upd_taken = 0;

      // Table-driven: allocate, saturate, alias, retarget
      foreach (vecs[i]) begin
         upd_en = vecs[i].en; upd_pc = vecs[i].pc; upd_taken = vecs[i].tk;
         upd_target = vecs[i].tgt; pc_f = vecs[i].look;
         tick();
         upd_en = 0; #1;
         chk($sformatf("v%0d_pred_f", i), br_pred_f, vecs[i].exp_pf);
         chk($sformatf("v%0d_pred_pc", i), br_pred_pc, vecs[i].exp_ppc);
         chk($sformatf("v%0d_hit", i), dut.f_hit, vecs[i].exp_hit);
         chk($sformatf("v%0d_ctr", i), dut.f_ctr, vecs[i].exp_ctr);
      end

      // Same-cycle lookup sees pre-update entry
      upd_en = 1; upd_pc = 32'h3050; upd_taken = 0; pc_f = 32'h3050; #1;
      chk("nobypass_pre", br_pred_f, 1);
      tick();
      upd_en = 0; #1;
      chk("nobypass_post", br_pred_f, 0);
      chk("nobypass_ctr", dut.f_ctr, 1);
      chk("tbl_cnt_branch", cnt_branch, 11);
      chk("tbl_cnt_miss", cnt_miss, 6);

      // Reset asserted during an update
      upd_en = 1; upd_pc = 32'h3010; upd_taken = 1; upd_target = 32'h7777_0000;
      pc_f = 32'h3050;
      #2 rst_n = 1'b0;
      tick();
      chk("midrst_cnt_branch", cnt_branch, 0);
      chk("midrst_pred_f", br_pred_f, 0);
      upd_en = 0; #2 rst_n = 1'b1;
      tick();
      pc_f = 32'h3010; #1;
      chk("midrst_lookup", dut.f_hit, 0);

      // Pipeline: allocate 0x3010 then stall / flush sequence
      upd_en = 1; upd_pc = 32'h3010; upd_taken = 1; upd_target = 32'h3040;
      tick();
      upd_en = 0; flush_d = 0; flush_e = 0; stall_d = 0; #1;
      chk("pipe_pred_f", br_pred_f, 1);
      tick();                                    // A: pred_d=1
      chk("pipe_A_e", br_pred_e, 0);
      stall_d = 1; flush_e = 1; pc_f = 32'h4000;
      tick();                                    // B
      chk("pipe_B_e", br_pred_e, 0);
      tick();                                    // C
      chk("pipe_C_e", br_pred_e, 0);
      stall_d = 0; flush_e = 0;
      tick();                                    // D: held pred_d reaches E
      chk("pipe_D_e", br_pred_e, 1);
      upd_en = 1; upd_pc = 32'h4000; upd_taken = 1; #1;
      chk("misp_taken_pred", mispredict, 0);
      upd_taken = 0; #1;
      chk("misp_nt_pred", mispredict, 1);
      upd_en = 0;
      pc_f = 32'h3010;
      tick();                                    // E: pred_d=1
      chk("pipe_E_e", br_pred_e, 0);
      stall_d = 1; flush_d = 1;
      tick();                                    // F: flush_d beats stall
      chk("pipe_F_e", br_pred_e, 1);
      stall_d = 0; flush_d = 0;
      tick();                                    // G
      chk("pipe_G_e", br_pred_e, 0);

      // Counters: 10 updates, 3 mispredicts (br_pred_e held at 0)
      rst_n = 0; flush_d = 1; flush_e = 1; #2 rst_n = 1;
      tick();
      pat = 10'b0100100010;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         upd_en = 1; upd_pc = 32'h5000; upd_taken = pat[i]; upd_target = 32'h5100;
         #1;
         if (mispredict) pulses++;
         tick();
      end
      upd_en = 0; #1;
      if (mispredict) pulses++;
      chk("cnt_branch", cnt_branch, 10);
      chk("cnt_miss", cnt_miss, 3);
      chk("misp_pulses", pulses, 3);
      tick();
      chk("cnt_branch_idle", cnt_branch, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
